// File: rtl/nor_gate_sweep_ctrl_pkg.sv
// Shared types and constants for the NOR-gate sweep controller.
// The golden truth table is built from one nibble per sel code, indexed by {a,b}.
package nor_sweep_pkg;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  localparam int IDX_W    = 5;
  localparam int N_POINTS = 32;

  localparam logic [3:0] OP_NOT_A = 4'h3;
  localparam logic [3:0] OP_NOR   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h8;
  localparam logic [3:0] OP_OR    = 4'hE;
  localparam logic [3:0] OP_XOR   = 4'h6;
  localparam logic [3:0] OP_XNOR  = 4'h9;
  localparam logic [3:0] OP_NAND  = 4'h7;

  // sel 7 repeats NAND, giving 32'h7796_E813
  localparam logic [31:0] GOLDEN_DEFAULT = {OP_NAND, OP_NAND, OP_XNOR, OP_XOR,
                                            OP_OR, OP_AND, OP_NOR, OP_NOT_A};

endpackage

// File: rtl/nor_gate_sweep_ctrl_if.sv
// Stimulus/response bus between the sweep controller and the gate unit.
interface nor_gate_sweep_ctrl_if;
  logic       dut_a;
  logic       dut_b;
  logic [2:0] dut_sel;
  logic       dut_out;

  modport master (output dut_a, output dut_b, output dut_sel, input dut_out);
  modport slave  (input dut_a, input dut_b, input dut_sel, output dut_out);
endinterface

// File: rtl/nor_gate_sweep_ctrl_settle.sv
// Settle timer: counts clocks a sweep point is held; last marks the sampling clock.
module sweep_settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);
  logic [3:0] cnt;

  assign last = (cnt == 4'(SETTLE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (en)
      cnt <= last ? 4'd0 : cnt + 4'd1;
  end
endmodule

// File: rtl/nor_gate_sweep_ctrl.sv
// Self-test sequencer sweeping all 32 {sel,a,b} points of the NOR gate unit.
// Optional macro SWEEP_FAIL_INDEX_EN adds fail_valid/fail_idx first-mismatch capture.
module nor_gate_sweep_ctrl
  import nor_sweep_pkg::*;
#(
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [31:0] GOLDEN        = GOLDEN_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  nor_gate_sweep_ctrl_if.master gate,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [N_POINTS-1:0]   result
`ifdef SWEEP_FAIL_INDEX_EN
  ,
  output logic                  fail_valid,
  output logic [IDX_W-1:0]      fail_idx
`endif
);

  state_t                state;
  logic [IDX_W-1:0]      idx;
  logic                  last;
  logic                  accept;
  logic                  sample;
  logic [N_POINTS-1:0]   next_result;

  assign accept = (state == IDLE) && start && !abort;
  assign sample = (state == SWEEP) && !abort && last;

  always_comb begin
    next_result      = result;
    next_result[idx] = gate.dut_out;
  end

  sweep_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept || ((state == SWEEP) && abort)),
    .en   (state == SWEEP),
    .last (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      result       <= '0;
      gate.dut_sel <= '0;
      gate.dut_a   <= 1'b0;
      gate.dut_b   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state  <= SWEEP;
            busy   <= 1'b1;
            idx    <= '0;
            result <= '0;
            pass   <= 1'b0;
            {gate.dut_sel, gate.dut_a, gate.dut_b} <= '0;
          end
        end
        SWEEP: begin
          if (abort) begin
            state  <= IDLE;
            busy   <= 1'b0;
            idx    <= '0;
            result <= '0;
            {gate.dut_sel, gate.dut_a, gate.dut_b} <= '0;
          end else if (sample) begin
            result <= next_result;
            if (idx == IDX_W'(N_POINTS - 1)) begin
              // pass is judged on the word including the bit just sampled
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (next_result == GOLDEN);
              {gate.dut_sel, gate.dut_a, gate.dut_b} <= '0;
            end else begin
              idx <= idx + 1'b1;
              {gate.dut_sel, gate.dut_a, gate.dut_b} <= idx + 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SWEEP_FAIL_INDEX_EN
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      fail_valid <= 1'b0;
      fail_idx   <= '0;
    end else if (sample && !fail_valid && (gate.dut_out != GOLDEN[idx])) begin
      fail_valid <= 1'b1;
      fail_idx   <= idx;
    end
  end
`endif

endmodule

// File: tb/tb_nor_gate_sweep_ctrl.sv
// Directed bench for nor_gate_sweep_ctrl: one instance with SETTLE_CYCLES=2, one with 1.
module tb_nor_gate_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        abort = 1'b0;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic [31:0] model0 = 32'h7796_E813;
  logic [31:0] model1 = 32'h7796_E813;

  logic        busy0, done0, pass0, busy1, done1, pass1;
  logic [31:0] result0, result1;
`ifdef SWEEP_FAIL_INDEX_EN
  logic        fail_valid0, fail_valid1;
  logic [4:0]  fail_idx0, fail_idx1;
`endif

  int vectors = 0;
  int miscompares = 0;

  nor_gate_sweep_ctrl_if gif0 ();
  nor_gate_sweep_ctrl_if gif1 ();

  assign gif0.dut_out = model0[{gif0.dut_sel, gif0.dut_a, gif0.dut_b}];
  assign gif1.dut_out = model1[{gif1.dut_sel, gif1.dut_a, gif1.dut_b}];

  nor_gate_sweep_ctrl #(.SETTLE_CYCLES(2), .GOLDEN(32'h7796_E813)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort), .gate(gif0),
    .busy(busy0), .done(done0), .pass(pass0), .result(result0)
`ifdef SWEEP_FAIL_INDEX_EN
    , .fail_valid(fail_valid0), .fail_idx(fail_idx0)
`endif
  );

  nor_gate_sweep_ctrl #(.SETTLE_CYCLES(1), .GOLDEN(32'h7796_E813)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort), .gate(gif1),
    .busy(busy1), .done(done1), .pass(pass1), .result(result1)
`ifdef SWEEP_FAIL_INDEX_EN
    , .fail_valid(fail_valid1), .fail_idx(fail_idx1)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] pt0();
    return {gif0.dut_sel, gif0.dut_a, gif0.dut_b};
  endfunction

  function automatic logic [4:0] pt1();
    return {gif1.dut_sel, gif1.dut_a, gif1.dut_b};
  endfunction

  // Pulses start0 so it is sampled at "edge 0", then returns in the clk where done0 is high.
  task automatic sweep0(input int limit, output int done_edge);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    done_edge = -1;
    for (int e = 1; e <= limit; e++) begin
      tick();
      if (done0) begin
        done_edge = e;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start0 = 1'b1;
    repeat (3) tick();
    vectors++; if ({busy0, done0, pass0} !== 3'b000) begin miscompares++;
      $display("FAIL reset_flags: got %b want 000", {busy0, done0, pass0}); end
    vectors++; if (result0 !== 32'h0) begin miscompares++;
      $display("FAIL reset_result: got %h want 00000000", result0); end
    vectors++; if (pt0() !== 5'd0) begin miscompares++;
      $display("FAIL reset_point: got %0d want 0", pt0()); end
    vectors++; if ({busy1, done1, pass1, result1} !== 35'h0) begin miscompares++;
      $display("FAIL reset_inst1: got %h want 0", {busy1, done1, pass1, result1}); end
    rst = 1'b0;
    tick();
    vectors++; if (busy0 !== 1'b1) begin miscompares++;
      $display("FAIL reset_release_busy: got %b want 1", busy0); end
    start0 = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_golden();
    int de;
    model0 = 32'h7796_E813;
    sweep0(100, de);
    vectors++; if (de !== 64) begin miscompares++;
      $display("FAIL golden_done_edge: got %0d want 64", de); end
    vectors++; if (result0 !== 32'h7796_E813) begin miscompares++;
      $display("FAIL golden_result: got %h want 7796e813", result0); end
    vectors++; if ({pass0, busy0} !== 2'b10) begin miscompares++;
      $display("FAIL golden_pass_busy: got %b want 10", {pass0, busy0}); end
`ifdef SWEEP_FAIL_INDEX_EN
    vectors++; if (fail_valid0 !== 1'b0) begin miscompares++;
      $display("FAIL golden_fail_valid: got %b want 0", fail_valid0); end
`endif
    tick();
    vectors++; if ({done0, pass0, result0} !== {2'b01, 32'h7796_E813}) begin miscompares++;
      $display("FAIL golden_hold: got %b %b %h want 0 1 7796e813", done0, pass0, result0); end
  endtask

  task automatic test_bad_nibble();
    int de;
    int first;
    model0 = 32'hF796_E813;
    sweep0(100, de);
    vectors++; if (de !== 64) begin miscompares++;
      $display("FAIL bad_done_edge: got %0d want 64", de); end
    vectors++; if (result0 !== 32'hF796_E813) begin miscompares++;
      $display("FAIL bad_result: got %h want f796e813", result0); end
    vectors++; if (pass0 !== 1'b0) begin miscompares++;
      $display("FAIL bad_pass: got %b want 0", pass0); end
    first = -1;
    for (int i = 31; i >= 0; i--) if (model0[i] != 32'h7796_E813 >> i & 1) first = i;
`ifdef SWEEP_FAIL_INDEX_EN
    vectors++; if ({fail_valid0, fail_idx0} !== {1'b1, 5'(first)}) begin miscompares++;
      $display("FAIL bad_fail_idx: got %b/%0d want 1/%0d", fail_valid0, fail_idx0, first); end
`endif
    tick();
    model0 = 32'h7796_E813;
  endtask

  task automatic test_abort();
    int de;
    bit seen;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (20) tick();
    vectors++; if (pt0() !== 5'd10) begin miscompares++;
      $display("FAIL abort_point: got %0d want 10", pt0()); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vectors++; if ({busy0, done0, result0} !== 34'h0) begin miscompares++;
      $display("FAIL abort_state: got %b %b %h want 0 0 00000000", busy0, done0, result0); end
    vectors++; if (pt0() !== 5'd0) begin miscompares++;
      $display("FAIL abort_point_clear: got %0d want 0", pt0()); end
    seen = 1'b0;
    repeat (80) begin tick(); if (done0 || busy0) seen = 1'b1; end
    vectors++; if (seen !== 1'b0) begin miscompares++;
      $display("FAIL abort_no_done: got activity %b want 0", seen); end
    sweep0(100, de);
    vectors++; if ({de == 64, result0} !== {1'b1, 32'h7796_E813}) begin miscompares++;
      $display("FAIL abort_resweep: got edge %0d result %h want 64 7796e813", de, result0); end
    tick();
  endtask

  task automatic test_start_held();
    int   dones;
    logic b65, b66;
    dones = 0; b65 = 1'bx; b66 = 1'bx;
    start0 = 1'b1;
    tick();
    for (int e = 1; e <= 66; e++) begin
      tick();
      if (done0) dones++;
      if (e == 65) b65 = busy0;
      if (e == 66) b66 = busy0;
    end
    vectors++; if (dones !== 1) begin miscompares++;
      $display("FAIL held_done_count: got %0d want 1", dones); end
    vectors++; if ({b65, b66} !== 2'b01) begin miscompares++;
      $display("FAIL held_restart: got busy65=%b busy66=%b want 0 1", b65, b66); end
    start0 = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_settle1();
    bit seen;
    model1 = 32'h7796_E813;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int k = 0; k < 32; k++) begin
      vectors++; if (pt1() !== 5'(k)) begin miscompares++;
        $display("FAIL s1_point_%0d: got %0d want %0d", k, pt1(), k); end
      tick();
    end
    vectors++; if ({done1, busy1, pass1, result1} !== {3'b101, 32'h7796_E813}) begin miscompares++;
      $display("FAIL s1_done: got %b%b%b %h want 101 7796e813", done1, busy1, pass1, result1); end
    tick();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (20) tick();
    vectors++; if (pt1() !== 5'd20) begin miscompares++;
      $display("FAIL s1_rst_point: got %0d want 20", pt1()); end
    rst = 1'b1;
    tick();
    vectors++; if ({busy1, done1, pass1, result1, pt1()} !== 40'h0) begin miscompares++;
      $display("FAIL s1_rst_outputs: got %b%b%b %h %0d want all 0", busy1, done1, pass1, result1, pt1()); end
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin tick(); if (done1) seen = 1'b1; end
    vectors++; if (seen !== 1'b0) begin miscompares++;
      $display("FAIL s1_rst_no_done: got %b want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_golden();
    test_bad_nibble();
    test_abort();
    test_start_held();
    test_settle1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
